// File: rtl/uart_pkg.sv
// Shared types and constants for the UART TX arbiter slice.
// The frame FSM state type is declared here so sub-modules and any
// future sibling blocks agree on one encoding.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic TXD_IDLE = 1'b1;

endpackage

// File: rtl/uart_rr_arbiter.sv
// Round-robin requester picker for the UART TX arbiter.
// Scans the valid vector starting one past the last granted ID and
// returns a one-hot grant plus the encoded winner. Purely combinational.
module uart_rr_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int IDW  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [IDW-1:0]   last_id,
    output logic [N_REQ-1:0] grant,
    output logic [IDW-1:0]   winner,
    output logic             found
);

    logic [IDW-1:0] cand;

    // first valid index after last_id, wrapping modulo N_REQ
    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDW'((int'(last_id) + k) % N_REQ);
            if (!found && valid[cand]) begin
                grant[cand] = 1'b1;
                winner      = cand;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX line among N_REQ byte requesters.
// Round-robin accept into a one-entry holding register; the frame FSM
// drains the holding register on the bit boundary so consecutive frames
// run with no idle bit between them. One bit per baudpulse.
// Optional feature: define UART_TX_ARB_PARITY_EN to append an even
// parity bit after the data bits.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1,
    localparam int IDW      = $clog2(N_REQ)
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       baudpulse,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*DATA_BITS-1:0] req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       txd,
    output logic [IDW-1:0]             tx_id,
    output logic                       busy,
    output logic                       frame_done
);

    localparam int BCW = $clog2(DATA_BITS + 1);
    localparam int SCW = $clog2(STOP_BITS + 1);

    tx_state_t            state;
    logic                 run_en;
    logic                 hold_valid;
    logic [DATA_BITS-1:0] hold_data;
    logic [IDW-1:0]       hold_id;
    logic [IDW-1:0]       last_id;
    logic [DATA_BITS-1:0] shreg;
    logic [BCW-1:0]       bit_cnt;
    logic [SCW-1:0]       stop_cnt;
`ifdef UART_TX_ARB_PARITY_EN
    logic                 parity_bit;
`endif

    logic [N_REQ-1:0]     grant;
    logic [IDW-1:0]       winner;
    logic                 found;
    logic [DATA_BITS-1:0] req_bytes [N_REQ];
    logic                 accept;
    logic                 drain;
    logic                 data_last;
    logic                 stop_last;

    for (genvar g = 0; g < N_REQ; g++) begin : g_bytes
        assign req_bytes[g] = req_data[g*DATA_BITS +: DATA_BITS];
    end

    uart_rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .valid   (req_valid),
        .last_id (last_id),
        .grant   (grant),
        .winner  (winner),
        .found   (found)
    );

    // run_en keeps READY low while reset is asserted, since grant alone follows VALID
    assign req_ready = (run_en && !hold_valid) ? grant : '0;
    assign accept    = run_en && !hold_valid && found;
    assign data_last = (bit_cnt == BCW'(DATA_BITS - 1));
    assign stop_last = (stop_cnt == SCW'(STOP_BITS - 1));
    assign drain     = baudpulse && hold_valid &&
                       ((state == IDLE) || ((state == STOP) && stop_last));
    assign busy      = (state != IDLE) || hold_valid;

    // holding register and round-robin pointer; a drain always beats a new accept
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            run_en     <= 1'b0;
            hold_valid <= 1'b0;
            hold_data  <= '0;
            hold_id    <= '0;
            last_id    <= IDW'(N_REQ - 1);
        end else begin
            run_en <= 1'b1;
            if (drain) begin
                hold_valid <= 1'b0;
            end else if (accept) begin
                hold_valid <= 1'b1;
                hold_data  <= req_bytes[winner];
                hold_id    <= winner;
                last_id    <= winner;
            end
        end
    end

    // frame FSM: every transition waits for baudpulse, TXD is registered
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= IDLE;
            txd        <= TXD_IDLE;
            tx_id      <= '0;
            shreg      <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= '0;
            frame_done <= 1'b0;
`ifdef UART_TX_ARB_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            if (baudpulse) begin
                case (state)
                    IDLE: begin
                        if (hold_valid) begin
                            state <= START;
                            txd   <= 1'b0;
                            shreg <= hold_data;
                            tx_id <= hold_id;
`ifdef UART_TX_ARB_PARITY_EN
                            parity_bit <= ^hold_data;
`endif
                        end
                    end
                    START: begin
                        state   <= DATA;
                        txd     <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_cnt <= '0;
                    end
                    DATA: begin
                        if (data_last) begin
`ifdef UART_TX_ARB_PARITY_EN
                            state <= PARITY;
                            txd   <= parity_bit;
`else
                            state    <= STOP;
                            txd      <= TXD_IDLE;
                            stop_cnt <= '0;
`endif
                        end else begin
                            txd     <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_cnt <= bit_cnt + BCW'(1);
                        end
                    end
`ifdef UART_TX_ARB_PARITY_EN
                    PARITY: begin
                        state    <= STOP;
                        txd      <= TXD_IDLE;
                        stop_cnt <= '0;
                    end
`endif
                    STOP: begin
                        if (stop_last) begin
                            frame_done <= 1'b1;
                            if (hold_valid) begin
                                // back-to-back: next start bit begins right here
                                state <= START;
                                txd   <= 1'b0;
                                shreg <= hold_data;
                                tx_id <= hold_id;
`ifdef UART_TX_ARB_PARITY_EN
                                parity_bit <= ^hold_data;
`endif
                            end else begin
                                state <= IDLE;
                                txd   <= TXD_IDLE;
                            end
                        end else begin
                            stop_cnt <= stop_cnt + SCW'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        txd   <= TXD_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
